// File: rtl/spi_bus_arbiter.sv
// ---------------------------------------------------------------------------
// spi_bus_arbiter
//
// Shares one flash SPI pad group between N_REQ SPI masters. Arbitration is
// round-robin: the search starts at the requester after the last owner.
// A grant is held until the owner drops its request; there is no preemption.
// After every release the bus is held idle (CS high) for GAP_CYCLES cycles,
// so the flash always sees a clean CS rising edge before a new owner starts.
//
// Ports
//   clk       system clock
//   rst       synchronous active-high reset
//   req       per-master bus request (level, held for whole ownership)
//   gnt       per-master grant, one-hot or zero, registered
//   m_sclk    per-master SCLK
//   m_cs      per-master CS (active-low)
//   m_sdo     per-master MOSI
//   m_sdi     MISO broadcast to all masters (wire from spi_sdi)
//   spi_sclk  pad SCLK
//   spi_cs    pad CS (active-low)
//   spi_sdo   pad MOSI
//   spi_sdi   pad MISO
//   busy      high while a master owns the bus or the gap is running
//   owner     index of current / last grantee
// ---------------------------------------------------------------------------
module spi_bus_arbiter #(
  parameter int N_REQ      = 2,
  parameter int GAP_CYCLES = 4,
  parameter int W_IDX      = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  input  logic [N_REQ-1:0] m_sclk,
  input  logic [N_REQ-1:0] m_cs,
  input  logic [N_REQ-1:0] m_sdo,
  output logic             m_sdi,
  output logic             spi_sclk,
  output logic             spi_cs,
  output logic             spi_sdo,
  input  logic             spi_sdi,
  output logic             busy,
  output logic [W_IDX-1:0] owner
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t             state, state_nx;
  logic [N_REQ-1:0]   gnt_nx;
  logic [W_IDX-1:0]   owner_nx;
  logic [7:0]         gap_cnt, gap_cnt_nx;

  logic               pick_found;
  logic [W_IDX-1:0]   pick_idx;
  logic [W_IDX-1:0]   cand;

  // Round-robin search: walk upward from owner+1, wrapping, and take the
  // first requester found. Wrapping through owner itself lets the last owner
  // win again when it is the only requester.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      cand = W_IDX'((int'(owner) + i) % N_REQ);
      if (!pick_found && req[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  always_comb begin
    state_nx   = state;
    gnt_nx     = gnt;
    owner_nx   = owner;
    gap_cnt_nx = gap_cnt;
    unique case (state)
      IDLE: begin
        if (pick_found) begin
          state_nx = GRANT;
          gnt_nx   = N_REQ'(1) << pick_idx;
          owner_nx = pick_idx;
        end
      end
      GRANT: begin
        if (!req[owner]) begin
          state_nx   = GAP;
          gnt_nx     = '0;
          gap_cnt_nx = 8'(GAP_CYCLES - 1);
        end
      end
      GAP: begin
        if (gap_cnt == 8'd0) begin
          state_nx = IDLE;
        end else begin
          gap_cnt_nx = gap_cnt - 8'd1;
        end
      end
      default: begin
        state_nx = IDLE;
        gnt_nx   = '0;
      end
    endcase
  end

  // owner resets to the last index so requester 0 wins the first search.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      gnt     <= '0;
      owner   <= W_IDX'(N_REQ - 1);
      gap_cnt <= 8'd0;
    end else begin
      state   <= state_nx;
      gnt     <= gnt_nx;
      owner   <= owner_nx;
      gap_cnt <= gap_cnt_nx;
    end
  end

  // Pads follow the owner only while in GRANT; otherwise the bus is parked
  // with CS high so a master releasing with CS low is cut off immediately.
  logic in_grant;
  assign in_grant = (state == GRANT);

  assign spi_sclk = in_grant ? m_sclk[owner] : 1'b0;
  assign spi_cs   = in_grant ? m_cs[owner]   : 1'b1;
  assign spi_sdo  = in_grant ? m_sdo[owner]  : 1'b0;
  assign m_sdi    = spi_sdi;
  assign busy     = (state != IDLE);

endmodule

// File: tb/tb_spi_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_spi_bus_arbiter
//
// Two arbiter instances run side by side: (N_REQ=2, GAP_CYCLES=4) and
// (N_REQ=3, GAP_CYCLES=1). A reference model tracks, per instance, who holds
// the bus and the first edge at which arbitration is allowed again; every
// cycle all outputs are compared against it.
// ---------------------------------------------------------------------------
module tb_spi_bus_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [7:0] rq  [2];
  logic [7:0] sc  [2];
  logic [7:0] cs  [2];
  logic [7:0] sd  [2];
  logic       sdi [2];

  logic [1:0] gnt0;
  logic [0:0] own0;
  logic       msdi0, sclk0, cs0, sdo0, busy0;
  logic [2:0] gnt1;
  logic [1:0] own1;
  logic       msdi1, sclk1, cs1, sdo1, busy1;

  spi_bus_arbiter #(.N_REQ(2), .GAP_CYCLES(4)) dut0 (
    .clk(clk), .rst(rst), .req(rq[0][1:0]), .gnt(gnt0),
    .m_sclk(sc[0][1:0]), .m_cs(cs[0][1:0]), .m_sdo(sd[0][1:0]), .m_sdi(msdi0),
    .spi_sclk(sclk0), .spi_cs(cs0), .spi_sdo(sdo0), .spi_sdi(sdi[0]),
    .busy(busy0), .owner(own0)
  );

  spi_bus_arbiter #(.N_REQ(3), .GAP_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .req(rq[1][2:0]), .gnt(gnt1),
    .m_sclk(sc[1][2:0]), .m_cs(cs[1][2:0]), .m_sdo(sd[1][2:0]), .m_sdi(msdi1),
    .spi_sclk(sclk1), .spi_cs(cs1), .spi_sdo(sdo1), .spi_sdi(sdi[1]),
    .busy(busy1), .owner(own1)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model: holder flag, holder index, and the edge number from
  // which an idle bus may be arbitrated again.
  int nreq [2] = '{2, 3};
  int gapc [2] = '{4, 1};
  bit m_gr    [2];
  int m_owner [2];
  int m_free  [2];
  int cyc = 0;

  task automatic mdl_edge(input int i);
    bit found;
    int c;
    if (rst) begin
      m_gr[i]    = 1'b0;
      m_owner[i] = nreq[i] - 1;
      m_free[i]  = cyc + 1;
    end else if (m_gr[i]) begin
      if (!rq[i][m_owner[i]]) begin
        m_gr[i]   = 1'b0;
        m_free[i] = cyc + gapc[i] + 1;
      end
    end else if (cyc >= m_free[i]) begin
      found = 1'b0;
      for (int k = 1; k <= nreq[i]; k++) begin
        c = (m_owner[i] + k) % nreq[i];
        if (!found && rq[i][c]) begin
          found      = 1'b1;
          m_gr[i]    = 1'b1;
          m_owner[i] = c;
        end
      end
    end
  endtask

  task automatic compare(input int i);
    int g, o, bz, sk, cz, so, mi;
    int e_gnt, e_sk, e_cs, e_so;
    if (i == 0) begin
      g = int'(gnt0); o = int'(own0); bz = int'(busy0);
      sk = int'(sclk0); cz = int'(cs0); so = int'(sdo0); mi = int'(msdi0);
    end else begin
      g = int'(gnt1); o = int'(own1); bz = int'(busy1);
      sk = int'(sclk1); cz = int'(cs1); so = int'(sdo1); mi = int'(msdi1);
    end
    e_gnt = m_gr[i] ? (1 << m_owner[i]) : 0;
    e_sk  = m_gr[i] ? int'(sc[i][m_owner[i]]) : 0;
    e_cs  = m_gr[i] ? int'(cs[i][m_owner[i]]) : 1;
    e_so  = m_gr[i] ? int'(sd[i][m_owner[i]]) : 0;
    chk($sformatf("u%0d gnt", i),   g,  e_gnt);
    chk($sformatf("u%0d owner", i), o,  m_owner[i]);
    chk($sformatf("u%0d busy", i),  bz, int'(m_gr[i] || (cyc + 1 < m_free[i])));
    chk($sformatf("u%0d sclk", i),  sk, e_sk);
    chk($sformatf("u%0d cs", i),    cz, e_cs);
    chk($sformatf("u%0d sdo", i),   so, e_so);
    chk($sformatf("u%0d sdi", i),   mi, int'(sdi[i]));
  endtask

  // One clock: model follows the inputs present at the edge, outputs are
  // sampled 1 time unit later, before the caller changes any input.
  task automatic step(input bit r);
    rst = r;
    @(posedge clk);
    mdl_edge(0);
    mdl_edge(1);
    #1;
    compare(0);
    compare(1);
    cyc++;
  endtask

  task automatic rand_pins();
    for (int i = 0; i < 2; i++) begin
      sc[i]  = 8'($urandom);
      cs[i]  = 8'($urandom);
      sd[i]  = 8'($urandom);
      sdi[i] = 1'($urandom);
    end
  endtask

  int held;

  initial begin
    for (int i = 0; i < 2; i++) begin
      rq[i] = '0; sc[i] = '0; cs[i] = '0; sd[i] = '0; sdi[i] = 1'b0;
      m_gr[i] = 1'b0; m_owner[i] = nreq[i] - 1; m_free[i] = 0;
    end
    step(1'b1);
    step(1'b1);

    // Simultaneous request, release with CS still low, then the other side.
    rq[0] = 8'b11;
    rq[1] = 8'b110;            // owner resets to 2, so grant wraps to 1
    for (int n = 0; n < 4; n++) begin rand_pins(); cs[0] = 8'h00; step(1'b0); end
    rq[0] = 8'b10;
    rq[1] = 8'b100;
    for (int n = 0; n < 8; n++) begin rand_pins(); cs[0] = 8'h00; step(1'b0); end
    rq[0] = 8'b00;
    rq[1] = 8'b000;
    for (int n = 0; n < 6; n++) begin rand_pins(); step(1'b0); end

    // Fairness: everyone requests, the holder releases after 10 cycles.
    held = 0;
    for (int n = 0; n < 120; n++) begin
      rand_pins();
      for (int i = 0; i < 2; i++) begin
        rq[i] = 8'((1 << nreq[i]) - 1);
        if (m_gr[i] && held >= 10) rq[i][m_owner[i]] = 1'b0;
      end
      held = m_gr[0] ? held + 1 : 0;
      step(1'b0);
    end

    // Reset in the middle of a grant with CS low.
    rq[0] = 8'b10; rq[1] = 8'b010;
    for (int n = 0; n < 3; n++) begin rand_pins(); cs[0] = 8'h00; cs[1] = 8'h00; step(1'b0); end
    rand_pins(); cs[0] = 8'h00; cs[1] = 8'h00; step(1'b1);
    rq[0] = 8'b11; rq[1] = 8'b111;
    for (int n = 0; n < 3; n++) begin rand_pins(); step(1'b0); end

    // Random traffic with occasional resets.
    for (int n = 0; n < 3000; n++) begin
      rand_pins();
      for (int i = 0; i < 2; i++)
        for (int b = 0; b < nreq[i]; b++)
          if ($urandom_range(0, 7) == 0) rq[i][b] = ~rq[i][b];
      step($urandom_range(0, 199) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/spi_bus_arbiter.md
# spi_bus_arbiter

Shares the single flash SPI pad group (SCLK, CS, SDO out; SDI in), routed by the GPIO pad mux, between N_REQ SPI masters, e.g. the boot flash loader and the processor's APB SPI master. Round-robin, grant-held-until-release arbitration. Enforces a fixed CS-deasserted gap between owners so the flash always sees a clean CS rising edge before a new transaction. Sits between the SPI masters and the gpio block's spi_sclk/spi_cs/spi_sdo/spi_sdi ports.

## Interface
- N_REQ, 2: number of requesting SPI masters, 2..8.
- GAP_CYCLES, 4: cycles of forced-idle bus between release and the next grant, 1..255.
- W_IDX, $clog2(N_REQ) (min 1): width of owner index.

- clk  in  1  system clock; single clock domain.
- rst  in  1  synchronous, active-high reset.
- req  in  N_REQ  per-master bus request; level, held for whole ownership.
- gnt  out  N_REQ  per-master grant; one-hot or zero, registered.
- m_sclk  in  N_REQ  per-master SCLK.
- m_cs  in  N_REQ  per-master CS, active-low.
- m_sdo  in  N_REQ  per-master MOSI.
- m_sdi  out  1  MISO broadcast to all masters (= spi_sdi, combinational, no gating).
- spi_sclk  out  1  to gpio spi_sclk.
- spi_cs  out  1  to gpio spi_cs, active-low.
- spi_sdo  out  1  to gpio spi_sdo.
- spi_sdi  in  1  from gpio spi_sdi.
- busy  out  1  high in GRANT or GAP.
- owner  out  W_IDX  index of current/last grantee.

## Operation
- FSM states: IDLE, GRANT, GAP. All state, gnt, owner, gap counter registered.
- IDLE: if any req bit is high, pick the first set bit searching upward from owner+1 (mod N_REQ), wrapping. Next edge: state=GRANT, gnt=onehot(pick), owner=pick. No req: stay IDLE.
- GRANT: while req[owner]=1, hold. Other requests are ignored; no preemption. When req[owner]=0 at an edge: state=GAP, gnt=0, counter=GAP_CYCLES-1.
- GAP: counter decrements each cycle. At counter==0 the next edge goes to IDLE. req sampled only in IDLE.
- Pad outputs are combinational from registered gnt/owner:
  - GRANT: spi_sclk=m_sclk[owner], spi_cs=m_cs[owner], spi_sdo=m_sdo[owner].
  - IDLE and GAP: spi_sclk=0, spi_cs=1, spi_sdo=0.
- Non-granted masters' pins have no effect on pads.
- Masters must not start a transaction before seeing gnt, and must return CS high before dropping req. The arbiter does not check this; a master dropping req with CS low gets CS forced high on the next cycle.
- Index arithmetic: owner+1 wraps to 0 at N_REQ-1. req bits above N_REQ do not exist.

## Timing
- Reset (rst high at edge): state=IDLE, gnt=0, owner=N_REQ-1 (requester 0 wins first arbitration), counter=0, busy=0. spi_cs=1, spi_sclk=0, spi_sdo=0 combinationally from reset state. rst overrides everything, including mid-GRANT (grant dropped, CS forced high next cycle).
- Grant latency: req high sampled at edge k in IDLE -> gnt high after edge k (1 cycle).
- Release: req low sampled at edge k -> gnt low and CS forced high after edge k. Bus stays idle for exactly GAP_CYCLES cycles. Earliest next gnt is after edge k+GAP_CYCLES+1.
- req toggled low then high during GAP: ignored until IDLE, then arbitrated normally.
- busy = state!=IDLE. owner is stable except on an IDLE->GRANT edge.
- Path m_* -> spi_* is a 2:1 (N:1) mux with no register. spi_sdi -> m_sdi is a wire.

## Test plan
- Reset, then req=2'b11 together -> gnt=2'b01 one cycle later, owner=0. Drop req[0] -> gnt=00 and spi_cs=1 for 4 cycles, then gnt=2'b10 one cycle after IDLE.
- Round-robin fairness: both masters request continuously, each releasing after 10 cycles -> grants alternate 0,1,0,1. Gap is exactly GAP_CYCLES=4 each time.
- Mux isolation: master 0 granted toggling sclk/sdo/cs. Master 1 drives random pins -> spi_* matches master 0 exactly. spi_sdi pattern appears on m_sdi every cycle.
- Bad release: master 0 drops req with m_cs[0]=0 -> spi_cs=1 the following cycle, gap still 4 cycles.
- Reset mid-GRANT: assert rst for 1 cycle while owner=1 with CS low -> gnt=0, spi_cs=1, owner=N_REQ-1 after edge. Next simultaneous request grants 0.
- N_REQ=3, GAP_CYCLES=1: req=3'b110 with owner=2 -> grant wraps to 1. Single-cycle gap verified.
